// File: rtl/pid_pkg.sv
// Shared types and helpers for the time-multiplexed PID controller.
package pid_pkg;

  typedef enum logic [2:0] {IDLE, ERR, MUL_P, MUL_I, MUL_D, SUM} pidState_e;

  function automatic int accWidth(input int width, input int gainW);
    return width + gainW + 3;
  endfunction

  function automatic logic signed [63:0] satSigned(input logic signed [63:0] value,
                                                    input logic signed [63:0] limit);
    if (value > limit) return limit;
    if (value < -limit) return -limit;
    return value;
  endfunction

endpackage

// File: rtl/pid_sat_clamp.sv
// Combinational symmetric clamp: limits a signed value to +/-LIM and narrows it to OUT_W bits.
module pid_sat_clamp
  import pid_pkg::*;
#(
  parameter int IN_W  = 17,
  parameter int OUT_W = 16,
  parameter int LIM   = 1023
) (
  input  logic signed [IN_W-1:0]  value,
  output logic signed [OUT_W-1:0] clamped
);

  always_comb begin
    clamped = OUT_W'(satSigned(64'(value), 64'(LIM)));
  end

endmodule

// File: rtl/pid_controller_seq.sv
// Time-multiplexed PID controller: one shared pipelined multiplier, clamped integral and output.
// Optional conditional integration (anti-windup) when PID_ANTIWINDUP_EN is defined.
//
// state | meaning
// IDLE  | waiting for sample_valid (or presenting the finished result)
// ERR   | error, derivative and integral update
// MUL_P | error * kp into the product register
// MUL_I | accumulate P, integral * ki
// MUL_D | accumulate I, derivative * kd
// SUM   | accumulate D, result goes out on the following edge
module pid_controller_seq
  import pid_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int GAIN_W   = 16,
  parameter int FRAC     = 4,
  parameter int ISUM_LIM = 1023,
  parameter int OUT_LIM  = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_valid,
  input  logic [WIDTH-1:0]  sample,
  input  logic [WIDTH-1:0]  setpoint,
  input  logic [GAIN_W-1:0] kp,
  input  logic [GAIN_W-1:0] ki,
  input  logic [GAIN_W-1:0] kd,
  output logic [WIDTH-1:0]  power,
  output logic              out_valid,
  output logic              busy,
  output logic              sat,
  output logic              dropped
);

  localparam int ACC_W  = accWidth(WIDTH, GAIN_W);
  localparam int PROD_W = WIDTH + GAIN_W + 1;
  localparam int W1     = WIDTH + 1;
  localparam int W2     = WIDTH + 2;
  localparam int WMAX   = (1 << (WIDTH - 1)) - 1;
  localparam logic signed [ACC_W-1:0] OUT_HI = ACC_W'(OUT_LIM);
  localparam logic signed [ACC_W-1:0] OUT_LO = -OUT_HI;

  pidState_e state, nextState;

  logic signed [WIDTH-1:0]  sampleR, setpointR, prevSample, integral, errR, dR;
  logic [GAIN_W-1:0]        kpR, kiR, kdR;
  logic                     first, doneR, accept;
  logic signed [PROD_W-1:0] prodR, prodNext;
  logic signed [ACC_W-1:0]  acc, rShift;
  logic signed [WIDTH-1:0]  opA, errSat, dSat, isumSat, powerNext;
  logic signed [GAIN_W:0]   opB;
  logic signed [W1-1:0]     errWide, dWide;
  logic signed [W2-1:0]     isumWide;
  logic                     satNext;

  assign accept = (state == IDLE) && !busy && sample_valid;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (accept) nextState = ERR;
      ERR:     nextState = MUL_P;
      MUL_P:   nextState = MUL_I;
      MUL_I:   nextState = MUL_D;
      MUL_D:   nextState = SUM;
      SUM:     nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    errWide  = W1'(sampleR) - W1'(setpointR);
    dWide    = W1'(sampleR) - W1'(prevSample);
    isumWide = W2'(integral) + W2'(errSat);
    opA = '0;
    opB = '0;
    case (state)
      MUL_P: begin opA = errR;     opB = {1'b0, kpR}; end
      MUL_I: begin opA = integral; opB = {1'b0, kiR}; end
      MUL_D: begin opA = dR;       opB = {1'b0, kdR}; end
      default: ;
    endcase
    prodNext = PROD_W'(opA) * PROD_W'(opB);
    rShift   = acc >>> FRAC;
    satNext  = (rShift > OUT_HI) || (rShift < OUT_LO);
  end

  pid_sat_clamp #(.IN_W(W1), .OUT_W(WIDTH), .LIM(WMAX)) errClamp (
    .value(errWide), .clamped(errSat));
  pid_sat_clamp #(.IN_W(W1), .OUT_W(WIDTH), .LIM(WMAX)) dClamp (
    .value(dWide), .clamped(dSat));
  pid_sat_clamp #(.IN_W(W2), .OUT_W(WIDTH), .LIM(ISUM_LIM)) isumClamp (
    .value(isumWide), .clamped(isumSat));
  pid_sat_clamp #(.IN_W(ACC_W), .OUT_W(WIDTH), .LIM(OUT_LIM)) outClamp (
    .value(rShift), .clamped(powerNext));

  always_ff @(posedge clk) begin
    if (rst) begin
      sampleR    <= '0;
      setpointR  <= '0;
      kpR        <= '0;
      kiR        <= '0;
      kdR        <= '0;
      prevSample <= '0;
      integral   <= '0;
      errR       <= '0;
      dR         <= '0;
      first      <= 1'b1;
      prodR      <= '0;
      acc        <= '0;
      doneR      <= 1'b0;
      power      <= '0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      sat        <= 1'b0;
      dropped    <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      dropped   <= sample_valid && busy;
      if (accept) begin
        sampleR   <= sample;
        setpointR <= setpoint;
        kpR       <= kp;
        kiR       <= ki;
        kdR       <= kd;
        busy      <= 1'b1;
      end
      case (state)
        ERR: begin
          errR       <= errSat;
          dR         <= first ? '0 : dSat;
          prevSample <= sampleR;
          first      <= 1'b0;
          acc        <= '0;
`ifdef PID_ANTIWINDUP_EN
          // hold the integrator while the output is pinned in the direction of the error
          if (!(sat && (errSat[WIDTH-1] == power[WIDTH-1]))) integral <= isumSat;
`else
          integral   <= isumSat;
`endif
        end
        MUL_P: prodR <= prodNext;
        MUL_I, MUL_D: begin
          acc   <= acc + {{2{prodR[PROD_W-1]}}, prodR};
          prodR <= prodNext;
        end
        SUM: begin
          acc   <= acc + {{2{prodR[PROD_W-1]}}, prodR};
          doneR <= 1'b1;
        end
        default: ;
      endcase
      // result leaves one edge after SUM; busy stays high through that cycle
      if (doneR) begin
        power     <= powerNext;
        sat       <= satNext;
        out_valid <= 1'b1;
        busy      <= 1'b0;
        doneR     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pid_controller_seq.sv
// Scoreboard bench for pid_controller_seq: stimulus pushes expected results, a monitor pops on out_valid.
module tb_pid_controller_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sample_valid = 1'b0;
  logic [15:0] sample = '0, setpoint = '0;
  logic [15:0] kp = '0, ki = '0, kd = '0;
  logic [15:0] power;
  logic        out_valid, busy, sat, dropped;

  pid_controller_seq dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample(sample), .setpoint(setpoint),
    .kp(kp), .ki(ki), .kd(kd), .power(power), .out_valid(out_valid), .busy(busy),
    .sat(sat), .dropped(dropped));

  always #5 clk = ~clk;

  typedef struct {int pw; bit st; longint cyc;} exp_t;
  exp_t sb[$];

  int     checks = 0, passes = 0;
  int     dropSeen = 0, dropExp = 0;
  longint cycleCnt = 0;

  // reference model state
  int mInt, mPrev, mLastPower;
  bit mFirst, mLastSat;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cycleCnt);
  endtask

  function automatic longint clampl(input longint v, input longint lim);
    if (v > lim) return lim;
    if (v < -lim) return -lim;
    return v;
  endfunction

  function automatic void modelReset();
    mInt = 0; mPrev = 0; mFirst = 1; mLastPower = 0; mLastSat = 0;
  endfunction

  function automatic void modelStep(input int s, input int sp, input int kpv, input int kiv,
                                    input int kdv, output int pw, output bit st);
    longint e, d, isum, acc, r;
    e    = clampl(longint'(s - sp), 32767);
    d    = mFirst ? 0 : clampl(longint'(s - mPrev), 32767);
    isum = clampl(mInt + e, 1023);
`ifdef PID_ANTIWINDUP_EN
    if (!(mLastSat && ((e < 0) == (mLastPower < 0)))) mInt = int'(isum);
`else
    mInt = int'(isum);
`endif
    mPrev  = s;
    mFirst = 0;
    acc = e * kpv + longint'(mInt) * kiv + d * kdv;
    r   = (acc - (((acc % 16) + 16) % 16)) / 16;   // floor division by 2^FRAC
    pw  = int'(clampl(r, 1023));
    st  = (r != pw);
    mLastPower = pw;
    mLastSat   = st;
  endfunction

  // mode 0: DUT only; 1: expect model result; 2: expect given constants (model still advanced)
  task automatic sendSample(input int s, input int sp, input int kpv, input int kiv, input int kdv,
                            input int mode, input int gp, input bit gs);
    int   guard = 0;
    int   mp;
    bit   ms;
    exp_t x;
    while (busy && guard < 50) begin @(negedge clk); guard++; end
    if (guard >= 50) check("busy_timeout", 1, 0);
    sample = 16'(s); setpoint = 16'(sp);
    kp = 16'(kpv); ki = 16'(kiv); kd = 16'(kdv);
    sample_valid = 1'b1;
    if (mode != 0) begin
      modelStep(s, sp, kpv, kiv, kdv, mp, ms);
      x.pw  = (mode == 2) ? gp : mp;
      x.st  = (mode == 2) ? gs : ms;
      x.cyc = cycleCnt + 7;
      sb.push_back(x);
    end
    @(negedge clk);
    sample_valid = 1'b0;
    kp = 16'($urandom); ki = 16'($urandom); kd = 16'($urandom);   // must not leak into this result
  endtask

  task automatic waitIdle();
    int guard = 0;
    while ((busy || sb.size() != 0) && guard < 60) begin @(negedge clk); guard++; end
    if (guard >= 60) check("idle_timeout", 1, 0);
    @(negedge clk);
  endtask

  task automatic doReset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    modelReset();
  endtask

  always @(negedge clk) begin
    if (!rst && dropped) dropSeen++;
    if (!rst && out_valid) begin
      if (sb.size() == 0) check("unexpected_out_valid", 1, 0);
      else begin
        exp_t x;
        x = sb.pop_front();
        check("power", longint'($signed(power)), x.pw);
        check("sat", sat, x.st);
        check("latency", cycleCnt, x.cyc);
        check("busy_clear", busy, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    modelReset();
    @(negedge clk);
    doReset();
    check("rst_power", power, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_sat", sat, 0);
    check("rst_dropped", dropped, 0);

    // derivative path from a fresh reset
    sendSample(100, 0, 0, 0, 16, 2, 0, 0);    waitIdle();
    sendSample(110, 0, 0, 0, 16, 2, 10, 0);   waitIdle();
    sendSample(105, 0, 0, 0, 16, 2, -5, 0);   waitIdle();

    // proportional
    sendSample(190, 180, 32, 0, 0, 2, 20, 0);  waitIdle();
    sendSample(170, 180, 32, 0, 0, 2, -20, 0); waitIdle();

    // output saturation both ways
    sendSample(50, 0, 1600, 0, 0, 2, 1023, 1);   waitIdle();
    sendSample(-50, 0, 1600, 0, 0, 2, -1023, 1); waitIdle();

    // integral with clamp, from zero integral
    doReset();
    sendSample(600, 0, 0, 16, 0, 2, 600, 0);  waitIdle();
    sendSample(600, 0, 0, 16, 0, 2, 1023, 0); waitIdle();
    sendSample(-100, 0, 0, 16, 0, 2, 923, 0); waitIdle();

    // second strobe two cycles after an accepted one is dropped
    sendSample(190, 180, 32, 0, 0, 2, 20, 0);
    @(negedge clk);
    sample = 16'(500); setpoint = '0; kp = 16'(1600); sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    check("dropped_pulse", dropped, 1);
    dropExp++;
    waitIdle();

    // reset in MUL_I aborts the computation
    sendSample(300, 0, 32, 16, 16, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    repeat (10) @(negedge clk);
    check("abort_power", power, 0);
    check("abort_busy", busy, 0);
    sendSample(100, 0, 0, 0, 16, 2, 0, 0); waitIdle();

    // randomized traffic against the model
    for (int i = 0; i < 40; i++) begin
      sendSample(int'($urandom_range(1600)) - 800, int'($urandom_range(400)) - 200,
                 int'($urandom_range(48)), int'($urandom_range(48)), int'($urandom_range(48)),
                 1, 0, 0);
      waitIdle();
    end

    repeat (4) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    check("dropped_count", dropSeen, dropExp);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
